// File: rtl/uart_rx_fifo_ctrl_if.sv
// Bus bundle between the uart_rx FIFO controller, the CPU and uart_rx.
// The slave view belongs to the controller, the master view to its surroundings.
interface uart_rx_fifo_ctrl_if;
    logic [7:0] o_dat;
    logic       i_addr;
    logic       i_we;
    logic       i_cyc;
    logic       o_int;
    logic       o_rx_cyc;
    logic       o_rx_addr;
    logic [7:0] i_rx_dat;
    logic       i_rx_int;

    modport slave (
        output o_dat, o_int, o_rx_cyc, o_rx_addr,
        input  i_addr, i_we, i_cyc, i_rx_dat, i_rx_int
    );

    modport master (
        input  o_dat, o_int, o_rx_cyc, o_rx_addr,
        output i_addr, i_we, i_cyc, i_rx_dat, i_rx_int
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Services uart_rx byte interrupts with a status-then-data read and buffers
// the bytes in a FIFO that the CPU drains at its own pace.
module uart_rx_fifo_ctrl #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int THRESHOLD = 1
) (
    input logic                i_clk,
    input logic                i_reset,
    uart_rx_fifo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_STAT, RD_DAT} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] THR_CNT  = (AW+1)'(THRESHOLD);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    state_t        state;
    logic          pend;
    logic          rx_cyc;
    logic          rx_addr;
    logic          irq;
    logic          uov;
    logic          fov;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [7:0]    mem [DEPTH];

    logic rd;
    logic pop_req;
    logic stat_rd;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic push_ok;
    logic fov_set;
    logic uov_set;
    logic [7:0] status;

    assign rd      = bus.i_cyc & ~bus.i_we;
    assign pop_req = rd & ~bus.i_addr;
    assign stat_rd = rd & bus.i_addr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = (state == RD_DAT);
    assign pop     = pop_req & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
    assign push_ok = push & (~full | pop);
    assign fov_set = push & ~push_ok;
    assign uov_set = (state == RD_STAT) & bus.i_rx_dat[1];
    assign status  = {4'd0, full, uov, fov, ~empty};

    assign bus.o_dat     = bus.i_addr ? status : mem[rd_ptr];
    assign bus.o_int     = irq;
    assign bus.o_rx_cyc  = rx_cyc;
    assign bus.o_rx_addr = rx_addr;

    always_comb begin
        count_nxt = count;
        unique case ({push_ok, pop})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= IDLE;
            pend    <= 1'b0;
            rx_cyc  <= 1'b0;
            rx_addr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_rx_int | pend) begin
                        state   <= RD_STAT;
                        pend    <= 1'b0;
                        rx_cyc  <= 1'b1;
                        rx_addr <= 1'b1;
                    end
                end
                RD_STAT: begin
                    if (bus.i_rx_int)
                        pend <= 1'b1;
                    state   <= RD_DAT;
                    rx_addr <= 1'b0;
                end
                RD_DAT: begin
                    if (bus.i_rx_int)
                        pend <= 1'b1;
                    state  <= IDLE;
                    rx_cyc <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    rx_cyc  <= 1'b0;
                    rx_addr <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.i_rx_dat;
    end

    // Sticky flags: a status read clears them, a coincident set wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            uov <= 1'b0;
            fov <= 1'b0;
            irq <= 1'b0;
        end else begin
            uov <= uov_set | (uov & ~stat_rd);
            fov <= fov_set | (fov & ~stat_rd);
            irq <= (count >= THR_CNT) | fov | uov;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench: two controllers (THRESHOLD 1 and 4) share stimulus;
// a queue scoreboard holds the bytes the CPU should read back.
module tb_uart_rx_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_fifo_ctrl_if bus ();
    uart_rx_fifo_ctrl_if bus4 ();

    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_stat = 8'h00;

    // uart_rx model: read data follows the address combinationally
    assign bus.i_rx_dat  = bus.o_rx_addr ? rx_stat : rx_byte;
    assign bus4.i_rx_dat = bus4.o_rx_addr ? rx_stat : rx_byte;
    assign bus4.i_addr   = bus.i_addr;
    assign bus4.i_we     = bus.i_we;
    assign bus4.i_cyc    = bus.i_cyc;
    assign bus4.i_rx_int = bus.i_rx_int;

    uart_rx_fifo_ctrl #(.DEPTH(16), .AW(4), .THRESHOLD(1)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    uart_rx_fifo_ctrl #(.DEPTH(16), .AW(4), .THRESHOLD(4)) dut4 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus4)
    );

    typedef enum {OP_RX, OP_POP, OP_STAT, OP_WR} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] arg;
        logic [7:0] stat;
        logic [7:0] exp;
        logic       exp_int;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] d;
    logic [7:0] d4;
    logic [7:0] e;

    function automatic void add(op_t op, logic [7:0] a, logic [7:0] s,
                                logic [7:0] x, logic xi);
        vec_t v;
        v.op = op; v.arg = a; v.stat = s; v.exp = x; v.exp_int = xi;
        tbl.push_back(v);
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] dat, input logic [7:0] st);
        rx_byte = dat;
        rx_stat = st;
        bus.i_rx_int = 1'b1;
        if (sb.size() < 16)
            sb.push_back(dat);
        tick();
        bus.i_rx_int = 1'b0;
        repeat (3) tick();
    endtask

    task automatic cpu_read(input logic a, input logic w,
                            output logic [7:0] rd, output logic [7:0] rd4);
        bus.i_cyc  = 1'b1;
        bus.i_addr = a;
        bus.i_we   = w;
        #4;
        rd  = bus.o_dat;
        rd4 = bus4.o_dat;
        tick();
        bus.i_cyc = 1'b0;
        bus.i_we  = 1'b0;
    endtask

    task automatic pop_chk(string name);
        logic [7:0] r;
        logic [7:0] r4;
        cpu_read(1'b0, 1'b0, r, r4);
        if (sb.size() > 0)
            check(name, r, sb.pop_front());
    endtask

    initial begin
        bus.i_addr = 1'b0;
        bus.i_we = 1'b0;
        bus.i_cyc = 1'b0;
        bus.i_rx_int = 1'b0;

        for (int i = 0; i < 16; i++)
            add(OP_RX, 8'(i), 8'h00, 8'h00, 1'b0);
        add(OP_WR, 8'h00, 8'h00, 8'h00, 1'b0);
        add(OP_WR, 8'h01, 8'h00, 8'h00, 1'b0);
        add(OP_STAT, 8'h00, 8'h00, 8'h09, 1'b1);
        add(OP_RX, 8'h10, 8'h00, 8'h00, 1'b0);
        add(OP_WR, 8'h01, 8'h00, 8'h00, 1'b0);
        add(OP_STAT, 8'h00, 8'h00, 8'h0B, 1'b1);
        add(OP_STAT, 8'h00, 8'h00, 8'h09, 1'b1);
        for (int i = 0; i < 16; i++)
            add(OP_POP, 8'h00, 8'h00, 8'h00, 1'b0);
        add(OP_POP, 8'h00, 8'h00, 8'h00, 1'b0);
        add(OP_STAT, 8'h00, 8'h00, 8'h00, 1'b0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        bus.i_addr = 1'b1;
        #1;
        check("rst_rx_cyc", {7'd0, bus.o_rx_cyc}, 8'h00);
        check("rst_rx_addr", {7'd0, bus.o_rx_addr}, 8'h00);
        check("rst_int", {7'd0, bus.o_int}, 8'h00);
        check("rst_status", bus.o_dat, 8'h00);
        tick();
        rst = 1'b0;
        tick();

        // single byte: cycle-exact sequence and interrupt latency
        rx_byte = 8'hA5;
        rx_stat = 8'h01;
        bus.i_rx_int = 1'b1;
        sb.push_back(8'hA5);
        #3;
        check("t1_c0_cyc", {7'd0, bus.o_rx_cyc}, 8'h00);
        tick();
        bus.i_rx_int = 1'b0;
        check("t1_c1_cyc", {7'd0, bus.o_rx_cyc}, 8'h01);
        check("t1_c1_addr", {7'd0, bus.o_rx_addr}, 8'h01);
        tick();
        check("t1_c2_cyc", {7'd0, bus.o_rx_cyc}, 8'h01);
        check("t1_c2_addr", {7'd0, bus.o_rx_addr}, 8'h00);
        tick();
        check("t1_c3_cyc", {7'd0, bus.o_rx_cyc}, 8'h00);
        check("t1_c3_int", {7'd0, bus.o_int}, 8'h00);
        tick();
        check("t1_c4_int", {7'd0, bus.o_int}, 8'h01);
        cpu_read(1'b1, 1'b0, d, d4);
        check("t1_status", d, 8'h01);
        pop_chk("t1_data");
        tick();
        check("t1_int_fall", {7'd0, bus.o_int}, 8'h00);

        // fill, overflow, write-ignore, drain in order
        foreach (tbl[i]) begin
            unique case (tbl[i].op)
                OP_RX: send_byte(tbl[i].arg, tbl[i].stat);
                OP_POP: pop_chk($sformatf("t2_pop%0d", i));
                OP_WR: cpu_read(tbl[i].arg[0], 1'b1, d, d4);
                OP_STAT: begin
                    check($sformatf("t2_int%0d", i), {7'd0, bus.o_int},
                          {7'd0, tbl[i].exp_int});
                    cpu_read(1'b1, 1'b0, d, d4);
                    check($sformatf("t2_stat%0d", i), d, tbl[i].exp);
                end
                default: ;
            endcase
        end

        // second interrupt during a read sequence is held pending
        rx_byte = 8'h31;
        rx_stat = 8'h00;
        bus.i_rx_int = 1'b1;
        sb.push_back(8'h31);
        tick();
        bus.i_rx_int = 1'b0;
        tick();
        bus.i_rx_int = 1'b1;
        sb.push_back(8'h32);
        tick();
        bus.i_rx_int = 1'b0;
        rx_byte = 8'h32;
        check("t3_idle_gap", {7'd0, bus.o_rx_cyc}, 8'h00);
        tick();
        check("t3_second_seq", {7'd0, bus.o_rx_cyc}, 8'h01);
        check("t3_second_addr", {7'd0, bus.o_rx_addr}, 8'h01);
        repeat (3) tick();
        cpu_read(1'b1, 1'b0, d, d4);
        check("t3_status", d, 8'h01);
        pop_chk("t3_pop0");
        pop_chk("t3_pop1");
        cpu_read(1'b1, 1'b0, d, d4);
        check("t3_status_empty", d, 8'h00);

        // full FIFO with a pop in the RD_DAT cycle
        for (int i = 0; i < 16; i++)
            send_byte(8'h40 + 8'(i), 8'h00);
        rx_byte = 8'h50;
        bus.i_rx_int = 1'b1;
        tick();
        bus.i_rx_int = 1'b0;
        tick();
        bus.i_cyc = 1'b1;
        bus.i_addr = 1'b0;
        #4;
        e = sb.pop_front();
        check("t4_pop_rd_dat", bus.o_dat, e);
        sb.push_back(8'h50);
        tick();
        bus.i_cyc = 1'b0;
        tick();
        cpu_read(1'b1, 1'b0, d, d4);
        check("t4_status", d, 8'h09);
        for (int i = 0; i < 16; i++)
            pop_chk($sformatf("t4_pop%0d", i));
        cpu_read(1'b1, 1'b0, d, d4);
        check("t4_status_empty", d, 8'h00);

        // uart overrun flag and THRESHOLD=4 interrupt
        send_byte(8'h60, 8'h02);
        rx_stat = 8'h00;
        check("t5_int4_uov", {7'd0, bus4.o_int}, 8'h01);
        cpu_read(1'b1, 1'b0, d, d4);
        check("t5_stat4", d4, 8'h05);
        check("t5_stat", d, 8'h05);
        tick();
        check("t5_int4_fall", {7'd0, bus4.o_int}, 8'h00);
        check("t5_int_cnt", {7'd0, bus.o_int}, 8'h01);
        cpu_read(1'b1, 1'b0, d, d4);
        check("t5_stat_clr", d, 8'h01);
        pop_chk("t5_pop");

        // reset in the middle of RD_STAT
        send_byte(8'h70, 8'h00);
        check("t6_int_pre", {7'd0, bus.o_int}, 8'h01);
        rx_byte = 8'h71;
        bus.i_rx_int = 1'b1;
        tick();
        bus.i_rx_int = 1'b0;
        check("t6_in_rd_stat", {7'd0, bus.o_rx_cyc}, 8'h01);
        rst = 1'b1;
        bus.i_addr = 1'b1;
        #1;
        check("t6_rx_cyc", {7'd0, bus.o_rx_cyc}, 8'h00);
        check("t6_int", {7'd0, bus.o_int}, 8'h00);
        check("t6_status", bus.o_dat, 8'h00);
        sb.delete();
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("t6_idle", {7'd0, bus.o_rx_cyc}, 8'h00);
        send_byte(8'h7E, 8'h00);
        pop_chk("t6_after");
        cpu_read(1'b1, 1'b0, d, d4);
        check("t6_final_status", d, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
